// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM encoding and
// the bit-counter width helper.
package serial_add_sub_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Width of the bit counter for a given operand width (counts 0..width-1).
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_add_sub_if.sv
// Request/result bundle of the bit-serial adder/subtractor.
interface serial_add_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b,
        input  busy, done, result, cout, ovf
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, result, cout, ovf
    );
endinterface

// File: rtl/full_adder.sv
// Existing 1-bit full adder cell.
module full_adder (
    output logic sum,
    output logic carry,
    input  logic a,
    input  logic b,
    input  logic ci
);
    assign sum   = a ^ b ^ ci;
    assign carry = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit adder/subtractor. Operands are loaded in parallel on
// an accepted start and processed LSB-first through a single full adder,
// one bit per clock. Subtraction feeds ~b with a carry-in of 1.
module serial_add_sub
    import serial_add_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_add_sub_if.slave bus
);
    localparam int             CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] stage;
    logic [WIDTH-1:0] result;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             cout;
    logic             ovf;
    logic             done;
    logic             fa_sum;
    logic             fa_co;
    logic             accept;
    logic             last;

    assign accept = (state == ST_IDLE) && bus.start;
    assign last   = (state == ST_RUN) && (cnt == LAST);

    full_adder u_fa (
        .sum   (fa_sum),
        .carry (fa_co),
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .ci    (carry)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next state: leave RUN after the last bit has been processed.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.start) state_nxt = ST_RUN;
            ST_RUN:  if (cnt == LAST) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Control and visible results: carry chain, bit counter, done pulse, flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry  <= 1'b0;
            cnt    <= '0;
            done   <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                carry <= bus.sub;
                cnt   <= '0;
            end else if (state == ST_RUN) begin
                carry <= fa_co;
                cnt   <= cnt + 1'b1;
                if (last) begin
                    // carry still holds the carry into the MSB at this edge
                    result <= {fa_sum, stage[WIDTH-1:1]};
                    cout   <= fa_co;
                    ovf    <= fa_co ^ carry;
                    done   <= 1'b1;
                end
            end
        end
    end

    // Operand shift registers and result staging; pure data, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_sr <= bus.a;
            b_sr <= bus.sub ? ~bus.b : bus.b;
        end else if (state == ST_RUN) begin
            a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
            stage <= {fa_sum, stage[WIDTH-1:1]};
        end
    end

    assign bus.busy   = (state == ST_RUN);
    assign bus.done   = done;
    assign bus.result = result;
    assign bus.cout   = cout;
    assign bus.ovf    = ovf;

endmodule

// File: tb/tb_serial_add_sub.sv
// Testbench for serial_add_sub: directed WIDTH=8 vectors, multi-cycle corner
// sequences, and exhaustive sweeps at WIDTH=2 and WIDTH=3.
module tb_serial_add_sub;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    serial_add_sub_if #(.WIDTH(8)) bus8 ();
    serial_add_sub_if #(.WIDTH(2)) bus2 ();
    serial_add_sub_if #(.WIDTH(3)) bus3 ();

    serial_add_sub #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_add_sub #(.WIDTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
    serial_add_sub #(.WIDTH(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    typedef struct {
        logic       s;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        logic       c;
        logic       o;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Entered and left at a negedge; returns at the negedge where done is seen.
    task automatic op8(input logic s, input logic [7:0] av, input logic [7:0] bv,
                       output logic [7:0] r, output logic c, output logic o,
                       output int lat, output bit stable);
        logic [7:0] prev;
        prev = bus8.result;
        bus8.start = 1'b1;
        bus8.sub   = s;
        bus8.a     = av;
        bus8.b     = bv;
        @(posedge clk);
        @(negedge clk);
        bus8.start = 1'b0;
        bus8.sub   = ~s;
        bus8.a     = ~av;
        bus8.b     = ~bv;
        lat    = 0;
        stable = 1'b1;
        while (!bus8.done && lat < 20) begin
            if (bus8.result !== prev) stable = 1'b0;
            @(negedge clk);
            lat++;
        end
        r = bus8.result;
        c = bus8.cout;
        o = bus8.ovf;
    endtask

    // One operation on the WIDTH=2 or WIDTH=3 instance.
    task automatic small_op(input int w, input bit s, input int av, input int bv,
                            output int r, output int c, output int o, output bit to);
        int n;
        if (w == 2) begin
            bus2.start = 1'b1; bus2.sub = s; bus2.a = av[1:0]; bus2.b = bv[1:0];
        end else begin
            bus3.start = 1'b1; bus3.sub = s; bus3.a = av[2:0]; bus3.b = bv[2:0];
        end
        @(posedge clk);
        @(negedge clk);
        bus2.start = 1'b0;
        bus3.start = 1'b0;
        n  = 0;
        to = 1'b0;
        while (!((w == 2) ? bus2.done : bus3.done)) begin
            if (n > 10) begin
                to = 1'b1;
                break;
            end
            @(negedge clk);
            n++;
        end
        if (w == 2) begin
            r = int'(bus2.result); c = int'(bus2.cout); o = int'(bus2.ovf);
        end else begin
            r = int'(bus3.result); c = int'(bus3.cout); o = int'(bus3.ovf);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r;
        logic       c;
        logic       o;
        int         lat;
        bit         stable;
        int         ndone;
        int         last_t;
        int         t;
        logic [7:0] seen_r;

        vecs[0] = '{1'b0, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
        vecs[6] = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 8'h55, 8'hAA, 8'hFF, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 8'h7F, 8'hFF, 8'h80, 1'b0, 1'b1};
        vecs[9] = '{1'b0, 8'hC0, 8'hC0, 8'h80, 1'b1, 1'b0};

        bus8.start = 1'b0; bus8.sub = 1'b0; bus8.a = '0; bus8.b = '0;
        bus2.start = 1'b0; bus2.sub = 1'b0; bus2.a = '0; bus2.b = '0;
        bus3.start = 1'b0; bus3.sub = 1'b0; bus3.a = '0; bus3.b = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_state", {21'd0, bus8.busy, bus8.done, bus8.cout, bus8.ovf, bus8.result},
              32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", {31'd0, bus8.busy}, 32'd0);

        // Directed vectors
        for (int i = 0; i < 10; i++) begin
            op8(vecs[i].s, vecs[i].a, vecs[i].b, r, c, o, lat, stable);
            check($sformatf("vec%0d_result", i), {24'd0, r}, {24'd0, vecs[i].r});
            check($sformatf("vec%0d_cout", i), {31'd0, c}, {31'd0, vecs[i].c});
            check($sformatf("vec%0d_ovf", i), {31'd0, o}, {31'd0, vecs[i].o});
            check($sformatf("vec%0d_latency", i), lat, 32'd8);
            check($sformatf("vec%0d_result_stable", i), {31'd0, stable}, 32'd1);
            @(negedge clk);
            check($sformatf("vec%0d_done_one_cycle", i), {30'd0, bus8.done, bus8.busy}, 32'd0);
        end

        // start while busy is ignored
        bus8.start = 1'b1; bus8.sub = 1'b0; bus8.a = 8'h12; bus8.b = 8'h34;
        @(posedge clk);
        @(negedge clk);
        bus8.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus8.start = 1'b1; bus8.sub = 1'b1; bus8.a = 8'h99; bus8.b = 8'h11;
        @(negedge clk);
        bus8.start = 1'b0;
        ndone  = 0;
        seen_r = 8'h00;
        for (int k = 0; k < 25; k++) begin
            if (bus8.done) begin
                ndone++;
                seen_r = bus8.result;
            end
            @(negedge clk);
        end
        check("busy_start_one_done", ndone, 32'd1);
        check("busy_start_result", {24'd0, seen_r}, 32'h46);

        // Reset mid-operation
        bus8.start = 1'b1; bus8.sub = 1'b0; bus8.a = 8'h21; bus8.b = 8'h11;
        @(posedge clk);
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midop_reset_outputs",
              {21'd0, bus8.busy, bus8.done, bus8.cout, bus8.ovf, bus8.result}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus8.done || bus8.busy) ndone++;
        end
        check("midop_reset_no_done", ndone, 32'd0);
        op8(1'b0, 8'h21, 8'h11, r, c, o, lat, stable);
        check("after_reset_op", {22'd0, c, o, r}, {22'd0, 1'b0, 1'b0, 8'h32});
        @(negedge clk);

        // Back-to-back with start held high
        bus8.start = 1'b1; bus8.sub = 1'b0; bus8.a = 8'h3C; bus8.b = 8'h05;
        ndone  = 0;
        last_t = -1;
        t      = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            t++;
            if (bus8.done) begin
                ndone++;
                check($sformatf("b2b_result%0d", ndone), {24'd0, bus8.result}, 32'h41);
                if (last_t >= 0) check($sformatf("b2b_interval%0d", ndone), t - last_t, 32'd9);
                last_t = t;
            end
        end
        check("b2b_done_count", ndone, 32'd4);
        bus8.start = 1'b0;
        t = 0;
        while ((bus8.busy || bus8.done) && t < 15) begin
            @(negedge clk);
            t++;
        end
        check("b2b_returns_idle", {30'd0, bus8.busy, bus8.done}, 32'd0);

        // Exhaustive sweep at WIDTH=2 and WIDTH=3 against a reference model
        for (int w = 2; w <= 3; w++) begin
            for (int s = 0; s < 2; s++) begin
                for (int av = 0; av < (1 << w); av++) begin
                    for (int bv = 0; bv < (1 << w); bv++) begin
                        int mask, bb, sum, er, ec, eo, sa, sb, sr, gr, gc, go;
                        bit to;
                        mask = (1 << w) - 1;
                        bb   = (s != 0) ? (~bv & mask) : bv;
                        sum  = av + bb + s;
                        er   = sum & mask;
                        ec   = (sum >> w) & 1;
                        sa   = (av >> (w - 1)) & 1;
                        sb   = (bv >> (w - 1)) & 1;
                        sr   = (er >> (w - 1)) & 1;
                        eo   = (s != 0) ? int'(sa != sb && sr != sa) : int'(sa == sb && sr != sa);
                        small_op(w, s[0], av, bv, gr, gc, go, to);
                        check($sformatf("sweep_w%0d_%s_%0d_%0d", w, (s != 0) ? "sub" : "add", av, bv),
                              (int'(to) << 12) | (gc << 9) | (go << 8) | gr,
                              (ec << 9) | (eo << 8) | er);
                        @(negedge clk);
                    end
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
